// File: rtl/led_sequencer.sv
// led_sequencer: command-driven LED pattern sequencer for the 8-bit LED bank.
//
// A command (mode, tick period, repeat count) is accepted over a valid/ready
// handshake while idle. In RUN the LED pattern advances once per tick. The run
// ends when the requested number of passes completes, which gives a one-cycle
// DONE pulse, or when ABORT arrives, which gives no pulse.
//
// Ports:
//   CLK         system clock
//   RST         synchronous, active-high reset
//   CMD_VALID   command present
//   CMD_READY   command can be accepted (IDLE)
//   CMD_MODE    0=COUNT 1=SHIFT 2=BOUNCE 3=BLINK
//   CMD_STEP    clocks per tick, 0 selects DEFAULT_STEP
//   CMD_REPEAT  passes to run, 0 runs until ABORT
//   ABORT       stop the current run
//   PAUSE       freeze the run (only when LED_SEQ_PAUSE_EN is defined)
//   LED         registered LED drive
//   BUSY        high in RUN
//   DONE        one-cycle pulse on completion of the final pass
//
// Optional feature macro: LED_SEQ_PAUSE_EN (adds the PAUSE input).
module led_sequencer #(
  parameter int DEFAULT_STEP = 10,
  parameter int STEP_W       = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD_MODE,
  input  logic [STEP_W-1:0] CMD_STEP,
  input  logic [7:0]        CMD_REPEAT,
  input  logic              ABORT,
`ifdef LED_SEQ_PAUSE_EN
  input  logic              PAUSE,
`endif
  output logic [7:0]        LED,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [1:0] M_COUNT  = 2'd0;
  localparam logic [1:0] M_SHIFT  = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_BLINK  = 2'd3;

  state_t            state, state_nx;
  logic [1:0]        mode_r;
  logic [STEP_W-1:0] step_r;
  logic [7:0]        rep_r;
  logic [STEP_W-1:0] presc;
  logic [7:0]        tick_idx;
  logic [7:0]        pass_cnt;
  logic [7:0]        led_r;
  logic              done_r;

  logic              advance;
  logic              tick;
  logic              pass_end;
  logic              final_tick;

  function automatic logic [7:0] init_pattern(input logic [1:0] m);
    return (m == M_SHIFT || m == M_BOUNCE) ? 8'h01 : 8'h00;
  endfunction

  function automatic logic [7:0] last_index(input logic [1:0] m);
    case (m)
      M_COUNT:  return 8'd255;
      M_SHIFT:  return 8'd7;
      M_BOUNCE: return 8'd13;
      default:  return 8'd1;
    endcase
  endfunction

  // BOUNCE is indexed by tick position: positions 0..7 climb, 8..13 descend,
  // and position 14 folds back to bit 0 through the same subtraction.
  function automatic logic [7:0] next_pattern(input logic [1:0] m,
                                              input logic [7:0] cur,
                                              input logic [7:0] idx);
    logic [7:0] n;
    logic [7:0] amt;
    n   = idx + 8'd1;
    amt = (n <= 8'd7) ? n : (8'd14 - n);
    case (m)
      M_COUNT:  return cur + 8'd1;
      M_SHIFT:  return {cur[6:0], cur[7]};
      M_BOUNCE: return 8'h01 << amt[2:0];
      default:  return ~cur;
    endcase
  endfunction

`ifdef LED_SEQ_PAUSE_EN
  assign advance = ~PAUSE;
`else
  assign advance = 1'b1;
`endif

  assign tick       = (presc == step_r - STEP_W'(1));
  assign pass_end   = tick && (tick_idx == last_index(mode_r));
  assign final_tick = pass_end && (rep_r != 8'd0) && (pass_cnt == rep_r - 8'd1);

  assign CMD_READY = (state == S_IDLE);
  assign BUSY      = (state == S_RUN);
  assign LED       = led_r;
  assign DONE      = done_r;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (CMD_VALID) state_nx = S_RUN;
      S_RUN: begin
        if (ABORT)                        state_nx = S_IDLE;
        else if (advance && final_tick)   state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      led_r    <= 8'h00;
      done_r   <= 1'b0;
      presc    <= '0;
      tick_idx <= 8'd0;
      pass_cnt <= 8'd0;
    end else begin
      done_r <= 1'b0;
      if (state == S_IDLE) begin
        if (CMD_VALID) begin
          mode_r   <= CMD_MODE;
          step_r   <= (CMD_STEP == '0) ? STEP_W'(DEFAULT_STEP) : CMD_STEP;
          rep_r    <= CMD_REPEAT;
          led_r    <= init_pattern(CMD_MODE);
          presc    <= '0;
          tick_idx <= 8'd0;
          pass_cnt <= 8'd0;
        end
      end else if (ABORT) begin
        // abort wins over a coincident final tick, so DONE stays low
        led_r <= 8'h00;
      end else if (advance) begin
        if (tick) begin
          presc <= '0;
          led_r <= next_pattern(mode_r, led_r, tick_idx);
          if (pass_end) begin
            tick_idx <= 8'd0;
            pass_cnt <= pass_cnt + 8'd1;
            if (final_tick) done_r <= 1'b1;
          end else begin
            tick_idx <= tick_idx + 8'd1;
          end
        end else begin
          presc <= presc + STEP_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

  logic        CLK;
  logic        RST;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_MODE;
  logic [31:0] CMD_STEP;
  logic [7:0]  CMD_REPEAT;
  logic        ABORT;
`ifdef LED_SEQ_PAUSE_EN
  logic        PAUSE;
`endif
  logic [7:0]  LED;
  logic        BUSY;
  logic        DONE;

  int checks = 0;
  int errors = 0;

  led_sequencer #(.DEFAULT_STEP(10), .STEP_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_MODE(CMD_MODE), .CMD_STEP(CMD_STEP), .CMD_REPEAT(CMD_REPEAT),
    .ABORT(ABORT),
`ifdef LED_SEQ_PAUSE_EN
    .PAUSE(PAUSE),
`endif
    .LED(LED), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] m;
    int         stp;
    int         rep;
    int         abort_at;
    bit         hold;
    logic [7:0] exp_led;
    int         exp_end;
    bit         exp_done;
  } vec_t;

  vec_t tbl[7];

  // Pattern shown after t ticks into a pass, written from the pattern rules.
  function automatic logic [7:0] pat(input logic [1:0] m, input int t);
    logic [7:0] one;
    one = 8'h01;
    case (m)
      2'd0:    return t[7:0];
      2'd1:    return one << t;
      2'd2:    return (t <= 7) ? (one << t) : (one << (14 - t));
      default: return (t % 2 == 1) ? 8'hFF : 8'h00;
    endcase
  endfunction

  function automatic int plen(input logic [1:0] m);
    case (m)
      2'd0:    return 256;
      2'd1:    return 8;
      2'd2:    return 14;
      default: return 2;
    endcase
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: {LED,BUSY,DONE,READY} got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issue one command and follow it cycle by cycle against the model.
  // k counts edges after the handshake edge; tick count is k/step.
  task automatic run_cmd(input logic [1:0] m, input int stp, input int rep,
                         input int abort_at, input bit hold_valid,
                         output logic [7:0] fin_led, output int end_k,
                         output bit saw_done);
    int es, len, kend;
    logic [7:0] eled;
    bit ebusy, edone, model_end;
    es   = (stp == 0) ? 10 : stp;
    len  = plen(m);
    kend = (rep == 0) ? 0 : es * len * rep;
    CMD_MODE = m; CMD_STEP = stp; CMD_REPEAT = rep[7:0];
    CMD_VALID = 1'b1; ABORT = 1'b0;
    cyc();
    if (hold_valid) begin
      CMD_MODE = m + 2'd1;
      CMD_STEP = 1;
    end else begin
      CMD_VALID = 1'b0;
    end
    check("start", {LED, BUSY, DONE, CMD_READY}, {pat(m, 0), 3'b100});
    end_k = -1; saw_done = 0; model_end = 0;
    eled = pat(m, 0);
    for (int k = 1; k <= 20000; k++) begin
      ABORT = (abort_at == k);
      cyc();
      if (abort_at != 0 && k >= abort_at) begin
        eled = 8'h00; ebusy = 0; edone = 0;
      end else if (rep != 0 && k >= kend) begin
        eled = pat(m, 0); ebusy = 0; edone = 1;
      end else begin
        eled = pat(m, (k / es) % len); ebusy = 1; edone = 0;
      end
      check("run", {LED, BUSY, DONE, CMD_READY}, {eled, ebusy, edone, !ebusy});
      if (DONE) saw_done = 1;
      if (!BUSY && end_k < 0) end_k = k;
      if (!ebusy) begin
        model_end = 1;
        break;
      end
    end
    ABORT = 1'b0; CMD_VALID = 1'b0;
    if (!model_end) begin
      errors++;
      $display("FAIL timeout: run did not end within cycle budget");
    end
    fin_led = LED;
    cyc();
    check("idle_hold", {LED, BUSY, DONE, CMD_READY}, {eled, 3'b001});
  endtask

  initial begin
    logic [7:0] fl;
    int ek;
    bit sd;

    tbl[0] = '{2'd1, 1, 1,  0, 0, 8'h01,   8, 1};
    tbl[1] = '{2'd3, 0, 3,  0, 0, 8'h00,  60, 1};
    tbl[2] = '{2'd0, 2, 0, 11, 1, 8'h00,  11, 0};
    tbl[3] = '{2'd2, 1, 1,  0, 0, 8'h01,  14, 1};
    tbl[4] = '{2'd2, 1, 1, 14, 0, 8'h00,  14, 0};
    tbl[5] = '{2'd0, 1, 1,  0, 0, 8'h00, 256, 1};
    tbl[6] = '{2'd1, 3, 2,  0, 0, 8'h01,  48, 1};

    RST = 1'b1; CMD_VALID = 1'b0; CMD_MODE = 2'd0; CMD_STEP = 0;
    CMD_REPEAT = 8'd0; ABORT = 1'b0;
`ifdef LED_SEQ_PAUSE_EN
    PAUSE = 1'b0;
`endif
    cyc();
    cyc();
    check("reset", {LED, BUSY, DONE, CMD_READY}, {8'h00, 3'b001});
    RST = 1'b0;
    cyc();
    check("post_reset", {LED, BUSY, DONE, CMD_READY}, {8'h00, 3'b001});

    for (int i = 0; i < 7; i++) begin
      run_cmd(tbl[i].m, tbl[i].stp, tbl[i].rep, tbl[i].abort_at, tbl[i].hold, fl, ek, sd);
      check_int($sformatf("vec%0d_final_led", i), fl, tbl[i].exp_led);
      check_int($sformatf("vec%0d_end_cycle", i), ek, tbl[i].exp_end);
      check_int($sformatf("vec%0d_done_seen", i), sd, tbl[i].exp_done);
    end

    // New command accepted in the DONE cycle.
    CMD_MODE = 2'd1; CMD_STEP = 1; CMD_REPEAT = 8'd1; CMD_VALID = 1'b1;
    cyc();
    CMD_VALID = 1'b0;
    for (int k = 1; k <= 8; k++) cyc();
    check("chain_done", {LED, BUSY, DONE, CMD_READY}, {8'h01, 3'b011});
    CMD_MODE = 2'd3; CMD_STEP = 1; CMD_REPEAT = 8'd1; CMD_VALID = 1'b1;
    cyc();
    CMD_VALID = 1'b0;
    check("chain_start", {LED, BUSY, DONE, CMD_READY}, {8'h00, 3'b100});
    cyc();
    check("chain_tick1", {LED, BUSY, DONE, CMD_READY}, {8'hFF, 3'b100});
    cyc();
    check("chain_done2", {LED, BUSY, DONE, CMD_READY}, {8'h00, 3'b011});

    // Reset mid-run, then ABORT while idle.
    CMD_MODE = 2'd1; CMD_STEP = 1; CMD_REPEAT = 8'd0; CMD_VALID = 1'b1;
    cyc();
    CMD_VALID = 1'b0;
    for (int k = 1; k <= 4; k++) cyc();
    check("pre_rst", {LED, BUSY, DONE, CMD_READY}, {8'h10, 3'b100});
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    check("mid_rst", {LED, BUSY, DONE, CMD_READY}, {8'h00, 3'b001});
    cyc();
    check("after_rst", {LED, BUSY, DONE, CMD_READY}, {8'h00, 3'b001});
    ABORT = 1'b1;
    cyc();
    ABORT = 1'b0;
    check("idle_abort", {LED, BUSY, DONE, CMD_READY}, {8'h00, 3'b001});

`ifdef LED_SEQ_PAUSE_EN
    begin
      int dk;
      dk = -1;
      CMD_MODE = 2'd1; CMD_STEP = 3; CMD_REPEAT = 8'd1; CMD_VALID = 1'b1;
      cyc();
      CMD_VALID = 1'b0;
      for (int k = 1; k <= 4; k++) cyc();
      PAUSE = 1'b1;
      for (int k = 5; k <= 9; k++) cyc();
      check("paused", {LED, BUSY, DONE, CMD_READY}, {8'h02, 3'b100});
      PAUSE = 1'b0;
      for (int k = 10; k <= 100; k++) begin
        cyc();
        if (DONE) begin
          dk = k;
          break;
        end
      end
      check_int("pause_done_cycle", dk, 29);
      check_int("pause_final_led", LED, 8'h01);
    end
`endif

    // Randomised commands against the model.
    for (int i = 0; i < 15; i++) begin
      logic [1:0] m;
      int stp, rep, es, kend, ab;
      m   = 2'($urandom_range(0, 3));
      stp = (m == 2'd0) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 3));
      rep = $urandom_range(0, 2);
      es  = (stp == 0) ? 10 : stp;
      kend = es * plen(m) * rep;
      if (rep == 0)                      ab = $urandom_range(1, 40);
      else if ($urandom_range(0, 1) == 1) ab = $urandom_range(1, kend);
      else                               ab = 0;
      run_cmd(m, stp, rep, ab, bit'($urandom_range(0, 1)), fl, ek, sd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
Pattern-sequencing controller for the 8-bit LED bank. It accepts commands over a valid/ready handshake. Each command selects a display mode, a tick period in clocks and a repeat count. The block steps the LED pattern once per tick until the requested passes complete or an abort arrives, and it replaces the fixed-rate free-running LED counter at the top level.

Parameters:
DEFAULT_STEP, 10, tick period used when CMD_STEP == 0
STEP_W, 32, width of the tick prescaler and CMD_STEP

Ports:
CLK  input  1  system clock
RST  input  1  reset; synchronous, active-high
CMD_VALID  input  1  command present
CMD_READY  output  1  block can accept a command (high only in IDLE)
CMD_MODE  input  2  0=COUNT, 1=SHIFT, 2=BOUNCE, 3=BLINK
CMD_STEP  input  STEP_W  clocks per tick; 0 selects DEFAULT_STEP
CMD_REPEAT  input  8  passes to run; 0 = run until ABORT
ABORT  input  1  stop the current run
LED  output  8  LED drive, registered
BUSY  output  1  high in RUN
DONE  output  1  one-cycle pulse when all passes complete

Behaviour:
- Reset (RST=1 at a CLK edge): state=IDLE, LED=8'h00, DONE=0, prescaler, tick index and pass counter all 0. RST mid-run aborts immediately and does not pulse DONE.
- States: IDLE, RUN. CMD_READY = (state==IDLE). BUSY = (state==RUN). Both decode combinationally from the state register.
- IDLE to RUN on the edge where CMD_VALID & CMD_READY:
  - latch mode, step (0 replaced by DEFAULT_STEP) and repeat;
  - LED <= the mode's initial pattern;
  - prescaler=0, tick index=0, pass=0.
  - CMD_VALID without CMD_READY is ignored; the command is not queued.
- RUN, per edge:
  - If prescaler == step-1: a tick occurs. Prescaler <= 0, LED <= next pattern, tick index increments.
  - Otherwise prescaler increments. First tick occurs `step` edges after the handshake edge.
- Pass lengths, initial values and next-pattern rules:
  - COUNT: length 256, initial 8'h00, next = LED+1 mod 256 (255 wraps to 0).
  - SHIFT: length 8, initial 8'h01, next = rotate left by 1 (8'h80 goes to 8'h01).
  - BOUNCE: length 14, initial 8'h01, sequence 01,02,04,...,80,40,...,02, then back to 01.
  - BLINK: length 2, initial 8'h00, next = ~LED.
  - Every pass ends with LED back at the initial pattern.
- Pass completion: a tick with tick index == length-1 completes a pass. Tick index <= 0 and the pass counter increments.
  - If repeat != 0 and this was pass number `repeat`: state <= IDLE and DONE <= 1 for exactly one cycle, coincident with the first IDLE cycle.
  - LED holds its final value in IDLE.
  - Repeat == 0 never completes. The pass counter wraps freely and has no effect.
- ABORT in RUN: next edge state <= IDLE, LED <= 8'h00, no DONE pulse. ABORT has priority over a simultaneous final tick. ABORT in IDLE is ignored.
- A new command is accepted on the first IDLE cycle, including the cycle DONE is high.
- Width rules:
  - prescaler is STEP_W bits and compares against the latched step;
  - tick index is 8 bits;
  - pass counter is 8 bits;
  - step == 1 produces a tick on every RUN edge.

Optional Feature:
LED_SEQ_PAUSE_EN
- Defined: adds input port PAUSE (1 bit). While PAUSE=1 in RUN, the prescaler, tick index, pass counter and LED all freeze. ABORT and RST still act. PAUSE is ignored in IDLE. A handshake while PAUSE=1 still loads and enters RUN, but ticking begins only once PAUSE is released.
- Undefined: no PAUSE port; RUN always advances.

Test Plan:
- Reset: RST high 2 cycles -> LED=00, CMD_READY=1, BUSY=0, DONE=0.
- SHIFT, step=1, repeat=1 -> LED 01 after the handshake edge; then 02,04,08,10,20,40,80,01 on 8 consecutive edges; DONE pulses 1 cycle with CMD_READY=1; LED holds 01.
- BLINK, step=0 (DEFAULT_STEP=10), repeat=3 -> LED toggles 00/FF every 10 clocks; 6 ticks total; DONE at clock 60 after the handshake; final LED=00.
- COUNT, step=2, repeat=0; ABORT asserted when LED=8'h05 -> next edge LED=00, state IDLE, no DONE; CMD_VALID held high during RUN is never accepted.
- BOUNCE, step=1, repeat=1 -> sequence 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01; DONE after 14 ticks. Separately, ABORT on the final-tick edge -> no DONE, LED=00.
- RST asserted mid-run with SHIFT at LED=8'h10 -> LED=00, IDLE. With LED_SEQ_PAUSE_EN: PAUSE held 5 cycles mid-tick -> the DONE pulse is delayed by exactly 5 cycles.
